data_memory_arbiter: RTL and testbench

- Shares the single-port 32x8 data memory between two requesters: port 0 (CPU load/store stage) and port 1 (debug/DMA loader).
- Serialises accesses, drives the memory's address/writedata/memread/memwrite, and returns read data with a done pulse.
- Sits between the requesters and the data memory. All memory control signals originate here.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arb_pick.sv | 32 +++
 rtl/data_memory_arbiter.sv | 147 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned DEF_MEM_DEPTH = 32;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way request picker; owns the arbitration policy.
// DATA_MEMORY_ARB_ROUND_ROBIN_EN selects round-robin, otherwise port 0 has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  output logic grant_valid,
  output logic grant_id
);

`ifdef DATA_MEMORY_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = ~last_served;
    end else begin
      grant_id = req1 ? PORT1 : PORT0;
    end
  end
`else
  logic unused_last_served;
  assign unused_last_served = last_served;

  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = req0 ? PORT0 : PORT1;
  end
`endif

endmodule

// File: rtl/data_memory_arbiter.sv
// Serialises two requesters onto a single-port data memory: IDLE -> ACCESS -> RESP.
// Tie policy set by DATA_MEMORY_ARB_ROUND_ROBIN_EN (see dmem_arb_pick).
module data_memory_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy
);

  state_e state_q, state_d;

  logic              grant_valid, grant_id, last_served, grant;
  logic              sel_we, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_capture;

  logic              id_q, we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;

  dmem_arb_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_served (last_served),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef DATA_MEMORY_ARB_ROUND_ROBIN_EN
  // Stored as the preferred port so that reset-to-zero still favours port 0 on the first tie.
  logic pref_q;
  assign last_served = ~pref_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pref_q <= 1'b0;
    end else if (grant) begin
      pref_q <= ~grant_id;
    end
  end
`else
  assign last_served = PORT1;
`endif

  assign grant      = (state_q == IDLE) && grant_valid;
  assign sel_we     = (grant_id == PORT1) ? we1 : we0;
  assign sel_addr   = (grant_id == PORT1) ? addr1 : addr0;
  assign sel_wdata  = (grant_id == PORT1) ? wdata1 : wdata0;
  assign sel_err    = 32'(sel_addr) >= MEM_DEPTH;
  assign rd_capture = (we_q || err_q) ? '0 : mem_readdata;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      id_q     <= PORT0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (grant) begin
        id_q    <= grant_id;
        we_q    <= sel_we;
        err_q   <= sel_err;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state_q == ACCESS) begin
        if (id_q == PORT1) rdata1_q <= rd_capture;
        else               rdata0_q <= rd_capture;
      end
    end
  end

  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    mem_memread   = 1'b0;
    mem_memwrite  = 1'b0;
    done0         = 1'b0;
    done1         = 1'b0;
    err0          = 1'b0;
    err1          = 1'b0;
    busy          = (state_q != IDLE);
    rdata0        = rdata0_q;
    rdata1        = rdata1_q;
    case (state_q)
      ACCESS: begin
        mem_address   = addr_q;
        mem_writedata = wdata_q;
        mem_memwrite  = we_q & ~err_q;
        mem_memread   = ~we_q & ~err_q;
      end
      RESP: begin
        done0 = (id_q == PORT0);
        done1 = (id_q == PORT1);
        err0  = (id_q == PORT0) & err_q;
        err1  = (id_q == PORT1) & err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed self-checking bench for data_memory_arbiter with a 32x8 memory model
// whose word i resets to value i.
module tb_data_memory_arbiter;

  logic       CLK, RESET_N;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       done0, err0, done1, err1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] mem_address, mem_writedata, mem_readdata;
  logic       mem_memread, mem_memwrite, busy;

  logic [7:0] mem [32];
  int         wr_cycles;
  int         checks = 0;
  int         errors = 0;
  int         w0;
  logic       exp_id;

  data_memory_arbiter dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .req0          (req0),
    .we0           (we0),
    .addr0         (addr0),
    .wdata0        (wdata0),
    .done0         (done0),
    .rdata0        (rdata0),
    .err0          (err0),
    .req1          (req1),
    .we1           (we1),
    .addr1         (addr1),
    .wdata1        (wdata1),
    .done1         (done1),
    .rdata1        (rdata1),
    .err1          (err1),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_memread   (mem_memread),
    .mem_memwrite  (mem_memwrite),
    .mem_readdata  (mem_readdata),
    .busy          (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign mem_readdata = (mem_address < 8'd32) ? mem[mem_address[4:0]] : 8'h00;

  // Memory model: write sampled mid-cycle while memwrite is asserted.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    wr_cycles = 0;
    forever begin
      @(negedge CLK);
      if (mem_memwrite === 1'b1) begin
        wr_cycles++;
        if (mem_address < 8'd32) mem[mem_address[4:0]] = mem_writedata;
      end
    end
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One complete transaction on a single port: IDLE (drive) -> ACCESS -> RESP -> IDLE.
  task automatic access(input logic port, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd, input logic exp_err);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
    step();
    check1("acc_busy", busy, 1'b1);
    check8("acc_addr", mem_address, addr);
    check8("acc_wdata", mem_writedata, wdata);
    check1("acc_memwrite", mem_memwrite, we & ~exp_err);
    check1("acc_memread", mem_memread, ~we & ~exp_err);
    check1("acc_no_done", done0 | done1, 1'b0);
    step();
    check1("resp_done", port ? done1 : done0, 1'b1);
    check1("resp_other_done", port ? done0 : done1, 1'b0);
    check1("resp_err", port ? err1 : err0, exp_err);
    check1("resp_other_err", port ? err0 : err1, 1'b0);
    check8("resp_rdata", port ? rdata1 : rdata0, exp_rd);
    check1("resp_mem_ctrl", mem_memread | mem_memwrite, 1'b0);
    check8("resp_addr_zero", mem_address, 8'h00);
    check1("resp_busy", busy, 1'b1);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
    step();
    check1("idle_busy", busy, 1'b0);
    check1("idle_no_done", done0 | done1, 1'b0);
  endtask

  initial begin
    RESET_N = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    #12;
    check1("rst_done0", done0, 1'b0);
    check1("rst_done1", done1, 1'b0);
    check1("rst_err", err0 | err1, 1'b0);
    check8("rst_rdata0", rdata0, 8'h00);
    check8("rst_rdata1", rdata1, 8'h00);
    check8("rst_mem_address", mem_address, 8'h00);
    check8("rst_mem_writedata", mem_writedata, 8'h00);
    check1("rst_mem_ctrl", mem_memread | mem_memwrite, 1'b0);
    check1("rst_busy", busy, 1'b0);
    @(negedge CLK);
    RESET_N = 1'b1;
    step();

    // Write then read back on port 0; the write strobe lasts exactly one cycle.
    w0 = wr_cycles;
    access(1'b0, 1'b1, 8'd3, 8'hA5, 8'h00, 1'b0);
    check1("write_one_cycle", wr_cycles == w0 + 1, 1'b1);
    access(1'b0, 1'b0, 8'd3, 8'h00, 8'hA5, 1'b0);

    // Reset during the ACCESS cycle of a write to address 5.
    w0 = wr_cycles;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd5; wdata0 = 8'h77;
    step();
    check1("mid_memwrite_before", mem_memwrite, 1'b1);
    #2;
    RESET_N = 1'b0;
    #1;
    check1("mid_memwrite_drop", mem_memwrite, 1'b0);
    check1("mid_busy", busy, 1'b0);
    check8("mid_rdata0_clr", rdata0, 8'h00);
    req0 = 1'b0; we0 = 1'b0;
    step();
    check1("mid_no_done", done0, 1'b0);
    @(negedge CLK);
    RESET_N = 1'b1;
    step();
    check1("post_rst_no_done", done0 | done1, 1'b0);
    check1("mid_no_write", wr_cycles == w0, 1'b1);
    access(1'b1, 1'b0, 8'd5, 8'h00, 8'd5, 1'b0);

    // Simultaneous reads; port 0 drops after its done, port 1 follows 3 cycles later.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd2;
    step();
    check8("tie_first_addr", mem_address, 8'd1);
    step();
    check1("tie_done0", done0, 1'b1);
    check1("tie_done1_low", done1, 1'b0);
    check8("tie_rdata0", rdata0, 8'd1);
    req0 = 1'b0;
    step();
    check1("tie_gap_busy", busy, 1'b0);
    step();
    check8("tie_second_addr", mem_address, 8'd2);
    step();
    check1("tie_done1", done1, 1'b1);
    check8("tie_rdata1", rdata1, 8'd2);
    req0 = 1'b1;
    step();

    // Both ports keep requesting: policy decides the grant order.
    for (int k = 0; k < 4; k++) begin
`ifdef DATA_MEMORY_ARB_ROUND_ROBIN_EN
      exp_id = k[0];
`else
      exp_id = 1'b0;
`endif
      step();
      step();
      check1("cont_done0", done0, ~exp_id);
      check1("cont_done1", done1, exp_id);
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      step();
      check1("cont_idle", busy, 1'b0);
    end

    // Out-of-range write on port 1, then read of an untouched word.
    w0 = wr_cycles;
    access(1'b1, 1'b1, 8'd40, 8'h33, 8'h00, 1'b1);
    check1("oor_no_write", wr_cycles == w0, 1'b1);
    access(1'b1, 1'b0, 8'd8, 8'h00, 8'd8, 1'b0);

    // Ten back-to-back reads on port 0.
    for (int i = 0; i < 10; i++) begin
      access(1'b0, 1'b0, 8'(i), 8'h00, (i == 3) ? 8'hA5 : 8'(i), 1'b0);
    end
    check8("p1_rdata_held", rdata1, 8'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
